// File: rtl/pim_tg_pkg.sv
// Shared definitions for the PIM traffic generator: address-mode encodings,
// FSM state type and the response-data fold used by the optional signature.
package pim_tg_pkg;

    localparam logic [1:0] TG_LINEAR = 2'd0;
    localparam logic [1:0] TG_WRAP   = 2'd1;
    localparam logic [1:0] TG_DESC   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } tg_state_t;

    // Widest response payload the fold accepts; narrower data is zero-extended.
    localparam int TG_FOLD_MAX = 4096;

    function automatic logic [31:0] tg_fold(input logic [TG_FOLD_MAX-1:0] d);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < TG_FOLD_MAX / 32; i++) begin
            acc = acc ^ d[i*32 +: 32];
        end
        return acc;
    endfunction

endpackage

// File: rtl/pim_tg_ts_fifo.sv
// Issue-timestamp FIFO: DEPTH entries of W bits, push and pop may coincide
// even when full; a pop on an empty FIFO is ignored.
module pim_tg_ts_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push_eff;
    logic          pop_eff;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) wr_ptr <= wr_ptr + PW'(1);
            if (pop_eff)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push_eff) - (PW+1)'(pop_eff);
        end
    end

endmodule

// File: rtl/pim_traffic_gen.sv
// Request generator / response monitor for the PIM system port.
// Optional response signature output is built when PIM_TG_SIGNATURE_EN is defined.
module pim_traffic_gen
    import pim_tg_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 512,
    parameter int CNT_W   = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            cfg_base_addr,
    input  logic [ADDR_W-1:0]            cfg_stride,
    input  logic [CNT_W-1:0]             cfg_num_ops,
    input  logic [1:0]                   cfg_mode,
    input  logic [ADDR_W-1:0]            cfg_window,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic [ADDR_W-1:0]            req_addr,
    input  logic                         resp_valid,
    output logic                         resp_ready,
    input  logic [DATA_W-1:0]            resp_data,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             sent_count,
    output logic [CNT_W-1:0]             recv_count,
    output logic [$clog2(MAX_OUT):0]     outstanding,
    output logic [CNT_W-1:0]             lat_sum,
    output logic [CNT_W-1:0]             lat_max,
    output logic                         err_unexpected,
    output tg_state_t                    dbg_state
`ifdef PIM_TG_SIGNATURE_EN
    ,
    output logic [31:0]                  sig
`endif
);
    localparam int OW = $clog2(MAX_OUT) + 1;

    tg_state_t         state;
    logic [ADDR_W-1:0] base_q, stride_q, window_q, off_q, off_nx;
    logic [CNT_W-1:0]  num_q, cyc, stamp, lat, sent_nx, recv_nx;
    logic [CNT_W:0]    sum_wide;
    logic [1:0]        mode_q;
    logic              req_hs, resp_hs, resp_cnt, launch;
    logic              unused_full, unused_empty;

    // Handshakes: a transfer happens on a clock edge where valid && ready;
    // req_addr is held stable while req_valid is high and req_ready is low.
    assign req_valid = (state == ST_RUN) && (sent_count < num_q) && (outstanding < OW'(MAX_OUT));
    assign req_hs    = req_valid && req_ready;
    assign resp_hs   = resp_valid && resp_ready;
    assign resp_cnt  = resp_hs && (outstanding != '0);
    assign launch    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign sent_nx   = sent_count + CNT_W'(req_hs);
    assign recv_nx   = recv_count + CNT_W'(resp_cnt);
    assign lat       = cyc - stamp;
    assign sum_wide  = {1'b0, lat_sum} + {1'b0, lat};
    assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

    // A zero window degenerates to plain linear stepping.
    always_comb begin
        off_nx = off_q + stride_q;
        if ((mode_q == TG_WRAP) && (window_q != '0) && (off_nx >= window_q)) begin
            off_nx = off_nx - window_q;
        end
    end

    pim_tg_ts_fifo #(.DEPTH(MAX_OUT), .W(CNT_W)) u_ts_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (launch),
        .push    (req_hs),
        .pop     (resp_cnt),
        .wr_data (cyc),
        .rd_data (stamp),
        .full    (unused_full),
        .empty   (unused_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            base_q         <= '0;
            stride_q       <= '0;
            window_q       <= '0;
            off_q          <= '0;
            num_q          <= '0;
            mode_q         <= '0;
            cyc            <= '0;
            req_addr       <= '0;
            resp_ready     <= 1'b0;
            sent_count     <= '0;
            recv_count     <= '0;
            outstanding    <= '0;
            lat_sum        <= '0;
            lat_max        <= '0;
            err_unexpected <= 1'b0;
        end else begin
            resp_ready  <= 1'b1;
            cyc         <= cyc + CNT_W'(1);
            outstanding <= outstanding + OW'(req_hs) - OW'(resp_cnt);
            if (resp_hs && (outstanding == '0)) err_unexpected <= 1'b1;
            if (resp_cnt) begin
                recv_count <= recv_nx;
                lat_sum    <= sum_wide[CNT_W] ? '1 : sum_wide[CNT_W-1:0];
                if (lat > lat_max) lat_max <= lat;
            end
            if (req_hs) begin
                sent_count <= sent_nx;
                off_q      <= off_nx;
                req_addr   <= (mode_q == TG_DESC) ? (base_q - off_nx) : (base_q + off_nx);
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        base_q         <= cfg_base_addr;
                        stride_q       <= cfg_stride;
                        window_q       <= cfg_window;
                        num_q          <= cfg_num_ops;
                        mode_q         <= cfg_mode;
                        off_q          <= '0;
                        req_addr       <= cfg_base_addr;
                        sent_count     <= '0;
                        recv_count     <= '0;
                        outstanding    <= '0;
                        lat_sum        <= '0;
                        lat_max        <= '0;
                        err_unexpected <= 1'b0;
                        state          <= (cfg_num_ops == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (req_hs && (sent_nx == num_q)) begin
                        state <= (recv_nx == num_q) ? ST_DONE : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (recv_nx == num_q) state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PIM_TG_SIGNATURE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (launch) begin
            sig <= '0;
        end else if (resp_cnt) begin
            sig <= {sig[30:0], sig[31]} ^ tg_fold(TG_FOLD_MAX'(resp_data));
        end
    end
`else
    logic unused_data;
    assign unused_data = ^resp_data;
`endif

endmodule
